// File: rtl/cv32e40p_debug_entry_sched.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_debug_entry_sched
// Purpose  : Latches and prioritises debug-entry causes, sequences the pipeline
//            flush, CSR-save strobe, debug mode and dret exit.
// Revision : 1.0 - initial release
// ============================================================================

module cv32e40p_debug_entry_sched #(
    parameter int unsigned FLUSH_TIMEOUT = 32,
    parameter int unsigned CAUSE_W       = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               trigger_match_i,
    input  logic               ebrk_insn_i,
    input  logic               ebrk_force_debug_mode_i,
    input  logic               debug_req_i,
    input  logic               debug_single_step_i,
    input  logic               instr_retired_i,
    input  logic               core_sleep_i,
    input  logic               flush_done_i,
    input  logic               data_err_i,
    input  logic               dret_i,
    output logic               flush_req_o,
    output logic               wakeup_o,
    output logic               csr_save_o,
    output logic [CAUSE_W-1:0] cause_o,
    output logic               debug_mode_o,
    output logic               err_abort_o,
    output logic               flush_timeout_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_TAKEN = 3'd2,
        ST_DBG   = 3'd3,
        ST_EXIT  = 3'd4
    } state_e;

    localparam int unsigned P_TRIG = 0;
    localparam int unsigned P_EBRK = 1;
    localparam int unsigned P_HALT = 2;
    localparam int unsigned P_STEP = 3;

    localparam logic [CAUSE_W-1:0] CAUSE_EBREAK  = CAUSE_W'(1);
    localparam logic [CAUSE_W-1:0] CAUSE_TRIGGER = CAUSE_W'(2);
    localparam logic [CAUSE_W-1:0] CAUSE_HALTREQ = CAUSE_W'(3);
    localparam logic [CAUSE_W-1:0] CAUSE_STEP    = CAUSE_W'(4);

    localparam logic [7:0] CNT_MAX = 8'(FLUSH_TIMEOUT);

    state_e             state_q;
    logic [3:0]         pend_q;
    logic [3:0]         pend_d;
    logic [7:0]         cnt_q;
    logic [7:0]         cnt_inc;
    logic               req;
    logic [CAUSE_W-1:0] cause_sel;

    logic               flush_req_q;
    logic               csr_save_q;
    logic [CAUSE_W-1:0] cause_q;
    logic               debug_mode_q;
    logic               err_abort_q;
    logic               flush_timeout_q;

    // New causes fold into the pending set before the FSM looks at it, so a
    // cause arriving in the same cycle as flush_done_i still competes.
    always_comb begin
        pend_d = pend_q;
        if (!debug_mode_q) begin
            pend_d = pend_q | {debug_single_step_i & instr_retired_i,
                               debug_req_i,
                               ebrk_insn_i & ebrk_force_debug_mode_i,
                               trigger_match_i};
        end
        req = |pend_d;

        cause_sel = CAUSE_STEP;
        if (pend_d[P_TRIG]) begin
            cause_sel = CAUSE_TRIGGER;
        end else if (pend_d[P_EBRK]) begin
            cause_sel = CAUSE_EBREAK;
        end else if (pend_d[P_HALT]) begin
            cause_sel = CAUSE_HALTREQ;
        end

        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            pend_q          <= '0;
            cnt_q           <= '0;
            flush_req_q     <= 1'b0;
            csr_save_q      <= 1'b0;
            cause_q         <= '0;
            debug_mode_q    <= 1'b0;
            err_abort_q     <= 1'b0;
            flush_timeout_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            csr_save_q  <= 1'b0;
            err_abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q     <= ST_FLUSH;
                        flush_req_q <= 1'b1;
                        cnt_q       <= '0;
                    end
                end
                ST_FLUSH: begin
                    cnt_q <= cnt_inc;
                    if (cnt_inc == CNT_MAX && !flush_done_i) begin
                        flush_timeout_q <= 1'b1;
                    end
                    // A bus error aborts this attempt; pending causes survive
                    // so the next cycle re-enters FLUSH.
                    if (data_err_i) begin
                        state_q     <= ST_IDLE;
                        flush_req_q <= 1'b0;
                        err_abort_q <= 1'b1;
                    end else if (flush_done_i) begin
                        state_q     <= ST_TAKEN;
                        flush_req_q <= 1'b0;
                        csr_save_q  <= 1'b1;
                        cause_q     <= cause_sel;
                    end
                end
                ST_TAKEN: begin
                    pend_q       <= '0;
                    state_q      <= ST_DBG;
                    debug_mode_q <= 1'b1;
                end
                ST_DBG: begin
                    if (dret_i) begin
                        state_q      <= ST_EXIT;
                        debug_mode_q <= 1'b0;
                    end
                end
                ST_EXIT: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    flush_req_q  <= 1'b0;
                    debug_mode_q <= 1'b0;
                end
            endcase
        end
    end

    assign wakeup_o        = core_sleep_i & (pend_q[P_HALT] | debug_req_i) & (state_q != ST_DBG);
    assign flush_req_o     = flush_req_q;
    assign csr_save_o      = csr_save_q;
    assign cause_o         = cause_q;
    assign debug_mode_o    = debug_mode_q;
    assign err_abort_o     = err_abort_q;
    assign flush_timeout_o = flush_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_debug_entry_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_debug_entry_sched
// Purpose  : Directed and random stimulus against a cycle-level cause model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_cv32e40p_debug_entry_sched;

    localparam int TMO = 4;

    localparam int PH_IDLE  = 0;
    localparam int PH_FLUSH = 1;
    localparam int PH_TAKEN = 2;
    localparam int PH_DBG   = 3;
    localparam int PH_EXIT  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig, ebrk, force_dbg, dbg_req, step, retired, sleep, done, derr, dret;
    logic       flush_req_o, wakeup_o, csr_save_o, debug_mode_o, err_abort_o, flush_timeout_o;
    logic [2:0] cause_o;

    cv32e40p_debug_entry_sched #(
        .FLUSH_TIMEOUT(TMO),
        .CAUSE_W      (3)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .trigger_match_i        (trig),
        .ebrk_insn_i            (ebrk),
        .ebrk_force_debug_mode_i(force_dbg),
        .debug_req_i            (dbg_req),
        .debug_single_step_i    (step),
        .instr_retired_i        (retired),
        .core_sleep_i           (sleep),
        .flush_done_i           (done),
        .data_err_i             (derr),
        .dret_i                 (dret),
        .flush_req_o            (flush_req_o),
        .wakeup_o               (wakeup_o),
        .csr_save_o             (csr_save_o),
        .cause_o                (cause_o),
        .debug_mode_o           (debug_mode_o),
        .err_abort_o            (err_abort_o),
        .flush_timeout_o        (flush_timeout_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending set indexed by DCSR cause code.
    bit m_pend [1:4];
    int m_phase;
    int m_visit;
    int m_cause;
    bit m_save, m_abort, m_tmo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_phase = PH_IDLE;
        m_visit = 0;
        m_cause = 0;
        m_save  = 1'b0;
        m_abort = 1'b0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_step();
        int best;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_phase != PH_DBG) begin
            if (trig)             m_pend[2] = 1'b1;
            if (ebrk && force_dbg) m_pend[1] = 1'b1;
            if (dbg_req)          m_pend[3] = 1'b1;
            if (step && retired)  m_pend[4] = 1'b1;
        end
        best = 0;
        if      (m_pend[2]) best = 2;
        else if (m_pend[1]) best = 1;
        else if (m_pend[3]) best = 3;
        else if (m_pend[4]) best = 4;
        m_save  = 1'b0;
        m_abort = 1'b0;
        case (m_phase)
            PH_IDLE: if (best != 0) begin
                m_phase = PH_FLUSH;
                m_visit = 0;
            end
            PH_FLUSH: begin
                m_visit++;
                if (m_visit >= TMO && !done) m_tmo = 1'b1;
                if (derr) begin
                    m_phase = PH_IDLE;
                    m_abort = 1'b1;
                end else if (done) begin
                    m_phase = PH_TAKEN;
                    m_save  = 1'b1;
                    m_cause = best;
                end
            end
            PH_TAKEN: begin
                foreach (m_pend[i]) m_pend[i] = 1'b0;
                m_phase = PH_DBG;
            end
            PH_DBG:  if (dret) m_phase = PH_EXIT;
            default: m_phase = PH_IDLE;
        endcase
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        logic exp_wake;
        #1;
        exp_wake = sleep & (m_pend[3] | dbg_req) & (m_phase != PH_DBG);
        chk("wakeup", wakeup_o, exp_wake);
        @(posedge clk);
        model_step();
        #1;
        chk("flush_req", flush_req_o, m_phase == PH_FLUSH);
        chk("csr_save", csr_save_o, m_save);
        chk("cause", cause_o, m_cause);
        chk("debug_mode", debug_mode_o, m_phase == PH_DBG);
        chk("err_abort", err_abort_o, m_abort);
        chk("timeout", flush_timeout_o, m_tmo);
        @(negedge clk);
    endtask

    task automatic clr();
        trig = 0; ebrk = 0; force_dbg = 0; dbg_req = 0; step = 0;
        retired = 0; sleep = 0; done = 0; derr = 0; dret = 0;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        model_reset();
        @(negedge clk);
        tick();
        tick();
        chk("rst_cause", cause_o, 0);
        chk("rst_dbg", debug_mode_o, 0);
        rst = 1'b0;
        tick();

        // Halt request pulse, flush_done three cycles later.
        dbg_req = 1; tick();
        dbg_req = 0; tick(); tick();
        chk("s1_flushreq", flush_req_o, 1);
        done = 1; tick();
        chk("s1_save", csr_save_o, 1);
        chk("s1_cause", cause_o, 3);
        done = 0; tick();
        chk("s1_dbg", debug_mode_o, 1);
        dret = 1; tick();
        dret = 0; tick(); tick();

        // Three simultaneous causes: trigger wins, others discarded.
        trig = 1; ebrk = 1; force_dbg = 1; dbg_req = 1; tick();
        clr(); done = 1; tick();
        chk("s2_cause", cause_o, 2);
        done = 0; tick();
        dret = 1; tick();
        dret = 0; tick(); tick(); tick();
        chk("s2_noreentry", flush_req_o, 0);

        // Bus error and flush_done together: abort, then retry.
        dbg_req = 1; tick();
        dbg_req = 0; done = 1; derr = 1; tick();
        chk("s3_abort", err_abort_o, 1);
        chk("s3_nosave", csr_save_o, 0);
        clr(); tick();
        chk("s3_reflush", flush_req_o, 1);
        done = 1; tick();
        chk("s3_cause", cause_o, 3);
        clr(); tick();
        dret = 1; tick();
        dret = 0; tick(); tick();

        // Single step; causes in debug mode ignored.
        step = 1; retired = 1; tick();
        retired = 0; done = 1; tick();
        chk("s4_cause", cause_o, 4);
        done = 0; tick();
        trig = 1; dbg_req = 1; tick();
        trig = 0; dbg_req = 0; dret = 1; tick();
        chk("s4_exit", debug_mode_o, 0);
        dret = 0; tick(); tick();
        chk("s4_idle", flush_req_o, 0);
        step = 0;

        // Flush timeout.
        dbg_req = 1; tick();
        dbg_req = 0; tick(); tick(); tick();
        chk("s5_pre_tmo", flush_timeout_o, 0);
        tick();
        chk("s5_tmo", flush_timeout_o, 1);
        tick(); tick();
        done = 1; tick();
        chk("s5_tmo_sticky", flush_timeout_o, 1);
        done = 0; tick();

        // Wakeup, then reset while in debug mode.
        dret = 1; tick();
        dret = 0; tick(); tick();
        sleep = 1; dbg_req = 1;
        #1 chk("s6_wake", wakeup_o, 1);
        tick();
        clr(); done = 1; tick();
        done = 0; tick();
        chk("s6_dbg", debug_mode_o, 1);
        rst = 1; tick();
        chk("s6_rst_dbg", debug_mode_o, 0);
        chk("s6_rst_tmo", flush_timeout_o, 0);
        rst = 0; tick();

        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            trig      = ($urandom_range(0, 99) < 4);
            ebrk      = ($urandom_range(0, 99) < 5);
            force_dbg = ($urandom_range(0, 99) < 50);
            dbg_req   = ($urandom_range(0, 99) < 4);
            step      = ($urandom_range(0, 99) < 30);
            retired   = ($urandom_range(0, 99) < 50);
            sleep     = ($urandom_range(0, 99) < 30);
            done      = ($urandom_range(0, 99) < 30);
            derr      = ($urandom_range(0, 99) < 10);
            dret      = ($urandom_range(0, 99) < 25);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
